reg_bank: RTL and testbench



---
 rtl/reg_bank.sv | 65 ++++++
 tb/tb_reg_bank.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// 32-entry register file: one write port, two registered read ports.
// Same-edge writes are forwarded to the read outputs; r0 is hardwired to 0.
module reg_bank #(
    parameter int DATA_W   = 32,
    parameter int SP_INDEX = 29,
    parameter int SP_RESET = 227
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [4:0]        WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [4:0]        ReadReg1,
    input  logic [4:0]        ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    logic [DATA_W-1:0] regs [32];
    logic              wr_en;
    logic [DATA_W-1:0] rd1_next;
    logic [DATA_W-1:0] rd2_next;

    assign wr_en = RegWrite && (WriteReg != 5'd0);

    // Forward the incoming write so a read never sees the stale value.
    always_comb begin
        rd1_next = regs[ReadReg1];
        if (ReadReg1 == 5'd0) begin
            rd1_next = '0;
        end else if (wr_en && (WriteReg == ReadReg1)) begin
            rd1_next = WriteData;
        end
    end

    always_comb begin
        rd2_next = regs[ReadReg2];
        if (ReadReg2 == 5'd0) begin
            rd2_next = '0;
        end else if (wr_en && (WriteReg == ReadReg2)) begin
            rd2_next = WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                if (i == SP_INDEX) begin
                    regs[i] <= DATA_W'(SP_RESET);
                end else begin
                    regs[i] <= '0;
                end
            end
            ReadData1 <= '0;
            ReadData2 <= '0;
        end else begin
            if (wr_en) begin
                regs[WriteReg] <= WriteData;
            end
            ReadData1 <= rd1_next;
            ReadData2 <= rd2_next;
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: directed vector table, hand sequences for
// mid-cycle corner cases, then a long random stream against a model.
module tb_reg_bank;

    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              RegWrite;
    logic [4:0]        WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [4:0]        ReadReg1;
    logic [4:0]        ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    int tests;
    int fails;

    reg_bank #(
        .DATA_W  (DATA_W),
        .SP_INDEX(29),
        .SP_RESET(227)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .RegWrite (RegWrite),
        .WriteReg (WriteReg),
        .WriteData(WriteData),
        .ReadReg1 (ReadReg1),
        .ReadReg2 (ReadReg2),
        .ReadData1(ReadData1),
        .ReadData2(ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic              we;
        logic [4:0]        wreg;
        logic [DATA_W-1:0] wdata;
        logic [4:0]        r1;
        logic [4:0]        r2;
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic [4:0] wreg,
                         input logic [DATA_W-1:0] wdata,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        reset     = rst;
        RegWrite  = we;
        WriteReg  = wreg;
        WriteData = wdata;
        ReadReg1  = r1;
        ReadReg2  = r2;
        @(posedge clk);
        #1;
    endtask

    logic [DATA_W-1:0] model [32];
    logic [DATA_W-1:0] exp1;
    logic [DATA_W-1:0] exp2;

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b0;
        RegWrite  = 1'b0;
        WriteReg  = '0;
        WriteData = '0;
        ReadReg1  = '0;
        ReadReg2  = '0;

        //            rst  we   wreg   wdata          r1     r2     e1             e2
        vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        vecs[1]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd29, 5'd0,  32'd227,      32'h0};
        vecs[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd5,  5'd29, 32'h0,        32'd227};
        vecs[3]  = '{1'b0, 1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 5'd8,  32'h0,        5'd8,  5'd1,  32'hDEADBEEF, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 5'd31, 32'h00400010, 5'd31, 5'd31, 32'h00400010, 32'h00400010};
        vecs[6]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd31, 32'h0,        32'h00400010};
        vecs[7]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd8,  32'h0,        32'hDEADBEEF};
        vecs[8]  = '{1'b0, 1'b1, 5'd29, 32'h1234,     5'd29, 5'd8,  32'h1234,     32'hDEADBEEF};
        vecs[9]  = '{1'b1, 1'b1, 5'd29, 32'h5678,     5'd29, 5'd29, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd29, 5'd8,  32'd227,      32'h0};
        vecs[11] = '{1'b0, 1'b1, 5'd3,  32'h11,       5'd3,  5'd31, 32'h11,       32'h0};
        vecs[12] = '{1'b0, 1'b1, 5'd3,  32'h22,       5'd3,  5'd0,  32'h22,       32'h0};
        vecs[13] = '{1'b0, 1'b0, 5'd3,  32'h99,       5'd3,  5'd3,  32'h22,       32'h22};

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].wreg, vecs[i].wdata,
                  vecs[i].r1, vecs[i].r2);
            check($sformatf("vec%0d_rd1", i), ReadData1, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), ReadData2, vecs[i].e2);
        end

        // Reset pulse that never spans a rising edge must be ignored.
        @(negedge clk);
        RegWrite = 1'b0;
        ReadReg1 = 5'd3;
        ReadReg2 = 5'd29;
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check("glitch_rst_rd1", ReadData1, 32'h22);
        check("glitch_rst_rd2", ReadData2, 32'd227);

        // Outputs hold while read indices change mid-cycle.
        #2;
        ReadReg1 = 5'd8;
        ReadReg2 = 5'd0;
        #1;
        check("hold_rd1", ReadData1, 32'h22);
        check("hold_rd2", ReadData2, 32'd227);
        @(posedge clk);
        #1;
        check("after_hold_rd1", ReadData1, 32'h0);
        check("after_hold_rd2", ReadData2, 32'h0);

        // Random stream against a simple array model.
        drive(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) model[i] = (i == 29) ? 32'd227 : 32'h0;

        for (int c = 0; c < 10000; c++) begin
            logic              rst;
            logic              we;
            logic [4:0]        wr;
            logic [4:0]        a;
            logic [4:0]        b;
            logic [DATA_W-1:0] wd;
            rst = ($urandom_range(0, 199) == 0);
            we  = $urandom_range(0, 1) == 1;
            wr  = ($urandom_range(0, 3) == 0) ? 5'(($urandom_range(0, 3))) : 5'($urandom);
            a   = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom);
            b   = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 7));
            wd  = $urandom;

            if (rst) begin
                exp1 = '0;
                exp2 = '0;
                for (int i = 0; i < 32; i++) model[i] = (i == 29) ? 32'd227 : 32'h0;
            end else begin
                exp1 = (a == 0) ? '0 : (we && wr != 0 && wr == a) ? wd : model[a];
                exp2 = (b == 0) ? '0 : (we && wr != 0 && wr == b) ? wd : model[b];
                if (we && wr != 0) model[wr] = wd;
            end

            drive(rst, we, wr, wd, a, b);
            check("rand_rd1", ReadData1, exp1);
            check("rand_rd2", ReadData2, exp2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
